// File: rtl/proc_pkg.sv
// Shared definitions for the multi-cycle sequencer and future pipelined
// variants of the same core.
//   state_t      : sequencer state enumeration (3-bit encoding)
//   EBREAK_INST  : EBREAK encoding, treated as a halt request
//   ZERO_INST    : all-zero word, treated as a halt (runaway fetch guard)
//   XLEN_DEFAULT : default datapath / address width
package proc_pkg;

    localparam int XLEN_DEFAULT = 64;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
    localparam logic [31:0] ZERO_INST   = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    function automatic logic is_halt_inst(input logic [31:0] word);
        return (word == EBREAK_INST) || (word == ZERO_INST);
    endfunction

endpackage

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer. Owns pc, the instruction register, the
// latched ALU result and the memory-data register, and steps each instruction
// through FETCH / DECODE / EXEC / MEM / WB with req/valid handshakes to the
// instruction and data memories. Detects halts and counts retirements.
//
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   imem_req/imem_addr                 fetch request (held until imem_valid)
//   imem_valid/imem_rdata              fetch response
//   inst                               instruction register, drives decode
//   dec_is_load/store/branch/reg_write decode class flags for inst
//   alu_result, br_taken, br_target    combinational datapath results
//   dmem_req/dmem_we/dmem_addr         data request (held until dmem_valid)
//   dmem_valid/dmem_rdata              data response
//   mdr, mem_to_reg, reg_write_en      write-back controls and load data
//   pc, retire, retired, halted        architectural status
module multicycle_sequencer
    import proc_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_valid,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      inst,
    input  logic             dec_is_load,
    input  logic             dec_is_store,
    input  logic             dec_is_branch,
    input  logic             dec_reg_write,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  br_target,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [XLEN-1:0]  dmem_addr,
    input  logic             dmem_valid,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic [XLEN-1:0]  mdr,
    output logic             mem_to_reg,
    output logic             reg_write_en,
    output logic [XLEN-1:0]  pc,
    output logic             retire,
    output logic [CNT_W-1:0] retired,
    output logic             halted
);

    state_t            state_reg, state_next;
    logic [31:0]       ir_reg, ir_next;
    logic [XLEN-1:0]   alu_q_reg, alu_q_next;
    logic [XLEN-1:0]   mdr_reg, mdr_next;
    logic [XLEN-1:0]   pc_reg, pc_next;
    logic [CNT_W-1:0]  retired_reg;
    logic              retire_reg;
    logic              retire_next;
    logic [XLEN-1:0]   pc_plus4;
    logic              is_mem;

    assign pc_plus4 = pc_reg + XLEN'(4);
    assign is_mem   = dec_is_load | dec_is_store;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_BOOT;
            ir_reg      <= '0;
            alu_q_reg   <= '0;
            mdr_reg     <= '0;
            pc_reg      <= RESET_PC;
            retired_reg <= '0;
            retire_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ir_reg      <= ir_next;
            alu_q_reg   <= alu_q_next;
            mdr_reg     <= mdr_next;
            pc_reg      <= pc_next;
            retire_reg  <= retire_next;
            if (retire_next) begin
                retired_reg <= retired_reg + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        ir_next     = ir_reg;
        alu_q_next  = alu_q_reg;
        mdr_next    = mdr_reg;
        pc_next     = pc_reg;
        retire_next = 1'b0;
        case (state_reg)
            ST_BOOT: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_valid) begin
                    ir_next    = imem_rdata;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_next = is_halt_inst(ir_reg) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                alu_q_next = alu_result;
                if (is_mem) begin
                    state_next = ST_MEM;
                end else if (dec_is_branch) begin
                    // A taken branch to a misaligned target stops the core
                    // before anything architectural changes.
                    if (br_taken && (br_target[1:0] != 2'b00)) begin
                        state_next = ST_HALT;
                    end else begin
                        pc_next     = br_taken ? br_target : pc_plus4;
                        retire_next = 1'b1;
                        state_next  = ST_FETCH;
                    end
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_valid) begin
                    // Store wins when both class flags are set.
                    if (dec_is_store) begin
                        pc_next     = pc_plus4;
                        retire_next = 1'b1;
                        state_next  = ST_FETCH;
                    end else begin
                        mdr_next   = dmem_rdata;
                        state_next = ST_WB;
                    end
                end
            end
            ST_WB: begin
                pc_next     = pc_plus4;
                retire_next = 1'b1;
                state_next  = ST_FETCH;
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    // Moore outputs: decoded from state and the IR-derived class flags only,
    // never from the memory valid inputs.
    assign imem_req     = (state_reg == ST_FETCH);
    assign imem_addr    = pc_reg;
    assign dmem_req     = (state_reg == ST_MEM);
    assign dmem_we      = dmem_req & dec_is_store;
    assign dmem_addr    = alu_q_reg;
    assign reg_write_en = (state_reg == ST_WB) & dec_reg_write;
    assign mem_to_reg   = (state_reg == ST_WB) & dec_is_load & ~dec_is_store;
    assign halted       = (state_reg == ST_HALT);

    // retire is registered alongside the counter, so it is high for exactly
    // the cycle in which retired first shows its incremented value.
    assign retire  = retire_reg;
    assign retired = retired_reg;
    assign inst    = ir_reg;
    assign mdr     = mdr_reg;
    assign pc      = pc_reg;

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

    localparam logic [63:0] RST_PC = 64'h100;

    typedef enum int {K_ALU, K_LOAD, K_STORE, K_LDST, K_BR, K_EBREAK, K_ZERO} kind_e;

    typedef struct {
        kind_e       kind;
        logic [31:0] word;
        logic        taken;
        logic [63:0] target;
        logic [63:0] alu;
        logic [63:0] rdata;
        int          iwait;
        int          dwait;
    } rec_t;

    typedef struct { logic [63:0] pc; int cnt; } ret_t;
    typedef struct { logic [63:0] addr; logic we; } dm_t;
    typedef struct { logic ld; logic [63:0] data; } wb_t;

    logic        clk, reset;
    logic        imem_req, imem_valid;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata, inst;
    logic        dec_is_load, dec_is_store, dec_is_branch, dec_reg_write;
    logic [63:0] alu_result, br_target, dmem_addr, dmem_rdata, mdr, pc;
    logic        br_taken, dmem_req, dmem_we, dmem_valid;
    logic        mem_to_reg, reg_write_en, retire, halted;
    logic [3:0]  retired;

    multicycle_sequencer #(.XLEN(64), .RESET_PC(RST_PC), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .inst(inst),
        .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
        .dec_is_branch(dec_is_branch), .dec_reg_write(dec_reg_write),
        .alu_result(alu_result), .br_taken(br_taken), .br_target(br_target),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_valid(dmem_valid), .dmem_rdata(dmem_rdata),
        .mdr(mdr), .mem_to_reg(mem_to_reg), .reg_write_en(reg_write_en),
        .pc(pc), .retire(retire), .retired(retired), .halted(halted)
    );

    // Stand-in decoder: opcode 7'h7f sets both load and store flags.
    logic [6:0] op;
    assign op            = inst[6:0];
    assign dec_is_load   = (op == 7'h03) || (op == 7'h7f);
    assign dec_is_store  = (op == 7'h23) || (op == 7'h7f);
    assign dec_is_branch = (op == 7'h63);
    assign dec_reg_write = (op == 7'h13) || (op == 7'h03);

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    rec_t  prog_q[$];
    ret_t  ret_q[$];
    dm_t   dm_q[$];
    wb_t   wb_q[$];
    int    ret_times[$];

    logic [63:0] m_pc;
    int          m_cnt;
    logic        m_halt;
    rec_t        cur_f;
    bit          f_act, d_act;
    int          icnt, dcnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic rec_t mk(input kind_e k, input int iw, input int dw,
                                input logic tk, input logic [63:0] tgt);
        rec_t r;
        logic [31:0] hi;
        hi       = $urandom() & 32'hFFFF_FF80;
        r.kind   = k;
        r.iwait  = iw;
        r.dwait  = dw;
        r.taken  = tk;
        r.target = tgt;
        r.alu    = {$urandom(), $urandom()};
        r.rdata  = {$urandom(), $urandom()};
        case (k)
            K_ALU:    r.word = hi | 32'h13;
            K_LOAD:   r.word = hi | 32'h03;
            K_STORE:  r.word = hi | 32'h23;
            K_LDST:   r.word = hi | 32'h7f;
            K_BR:     r.word = hi | 32'h63;
            K_EBREAK: r.word = 32'h0010_0073;
            default:  r.word = 32'h0;
        endcase
        return r;
    endfunction

    // Reference model: architectural effect of one fetched instruction.
    task automatic step(input logic [63:0] npc);
        m_pc = npc;
        m_cnt++;
        ret_q.push_back('{m_pc, m_cnt % 16});
    endtask

    task automatic model_fetch(input rec_t r);
        check("fetch_addr", imem_addr, m_pc);
        case (r.kind)
            K_EBREAK, K_ZERO: m_halt = 1'b1;
            K_ALU: begin
                wb_q.push_back('{1'b0, 64'h0});
                step(m_pc + 64'd4);
            end
            K_LOAD: begin
                dm_q.push_back('{r.alu, 1'b0});
                wb_q.push_back('{1'b1, r.rdata});
                step(m_pc + 64'd4);
            end
            K_STORE, K_LDST: begin
                dm_q.push_back('{r.alu, 1'b1});
                step(m_pc + 64'd4);
            end
            default: begin
                if (r.taken && (r.target % 4 != 0)) m_halt = 1'b1;
                else step(r.taken ? r.target : m_pc + 64'd4);
            end
        endcase
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory agent: drives responses at the falling edge with the per-record
    // wait counts.
    initial begin
        imem_valid = 0; dmem_valid = 0; imem_rdata = '0; dmem_rdata = '0;
        alu_result = '0; br_taken = 0; br_target = '0;
        f_act = 0; d_act = 0; icnt = 0; dcnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                imem_valid = 0; dmem_valid = 0; f_act = 0; d_act = 0;
            end else begin
                if (imem_valid) begin
                    imem_valid = 0;
                    f_act = 0;
                end else if (imem_req) begin
                    if (!f_act && prog_q.size() > 0) begin
                        cur_f = prog_q.pop_front();
                        f_act = 1;
                        icnt  = cur_f.iwait;
                    end
                    if (f_act) begin
                        if (icnt == 0) begin
                            imem_valid = 1;
                            imem_rdata = cur_f.word;
                            alu_result = cur_f.alu;
                            br_taken   = cur_f.taken;
                            br_target  = cur_f.target;
                            model_fetch(cur_f);
                        end else icnt--;
                    end
                end
                if (dmem_valid) begin
                    dmem_valid = 0;
                    d_act = 0;
                end else if (dmem_req) begin
                    if (!d_act) begin
                        d_act = 1;
                        dcnt  = cur_f.dwait;
                    end
                    if (dcnt == 0) begin
                        dmem_valid = 1;
                        dmem_rdata = cur_f.rdata;
                    end else dcnt--;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a transaction.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (!reset) begin
                if (retire) begin
                    ret_times.push_back(cyc);
                    $display("retire pc=%h retired=%0d cycle=%0d", pc, retired, cyc);
                    if (ret_q.size() == 0) check("retire_unexpected", 64'd1, 64'd0);
                    else begin
                        ret_t e;
                        e = ret_q.pop_front();
                        check("retire_pc", pc, e.pc);
                        check("retire_count", 64'(retired), 64'(e.cnt));
                    end
                end
                if (dmem_req && dmem_valid) begin
                    if (dm_q.size() == 0) check("dmem_unexpected", 64'd1, 64'd0);
                    else begin
                        dm_t d;
                        d = dm_q.pop_front();
                        check("dmem_addr", dmem_addr, d.addr);
                        check("dmem_we", 64'(dmem_we), 64'(d.we));
                    end
                end
                if (reg_write_en) begin
                    if (wb_q.size() == 0) check("wb_unexpected", 64'd1, 64'd0);
                    else begin
                        wb_t w;
                        w = wb_q.pop_front();
                        check("mem_to_reg", 64'(mem_to_reg), 64'(w.ld));
                        if (w.ld) check("mdr", mdr, w.data);
                    end
                end
                if (halted)
                    check("halt_quiet", 64'({imem_req, dmem_req, reg_write_en, retire}), 64'd0);
            end
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("rst_pc", pc, RST_PC);
        check("rst_retired", 64'(retired), 64'd0);
        check("rst_ir", 64'(inst), 64'd0);
        check("rst_mdr_alu", {mdr[31:0], dmem_addr[31:0]}, 64'd0);
        check("rst_strobes", 64'({imem_req, dmem_req, dmem_we, reg_write_en,
                                  mem_to_reg, retire, halted}), 64'd0);
        repeat (2) @(negedge clk);
        prog_q.delete(); ret_q.delete(); dm_q.delete(); wb_q.delete();
        ret_times.delete();
        m_pc = RST_PC; m_cnt = 0; m_halt = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("boot_no_req", 64'(imem_req), 64'd0);
        @(posedge clk);
        #1;
        check("first_req", 64'(imem_req), 64'd1);
        check("first_addr", imem_addr, RST_PC);
    endtask

    task automatic run_prog(input int bound);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        while (!done && n < bound) begin
            @(negedge clk);
            #1;
            n++;
            if (m_halt) done = halted;
            else done = (prog_q.size() == 0) && !f_act && (ret_q.size() == 0)
                        && (dm_q.size() == 0) && (wb_q.size() == 0);
        end
        check("run_complete", 64'(done), 64'd1);
    endtask

    task automatic end_checks();
        check("end_pc", pc, m_pc);
        check("end_retired", 64'(retired), 64'(m_cnt % 16));
        check("end_halted", 64'(halted), 64'(m_halt));
    endtask

    task automatic check_intervals(input int exp[$]);
        if (ret_times.size() < exp.size() + 1) begin
            check("interval_count", 64'(ret_times.size()), 64'(exp.size() + 1));
        end else begin
            for (int i = 0; i < exp.size(); i++)
                check("latency", 64'(ret_times[i + 1] - ret_times[i]), 64'(exp[i]));
        end
    endtask

    initial begin
        int ints[$];
        reset = 1'b1;
        m_pc = RST_PC; m_cnt = 0; m_halt = 0;
        repeat (2) @(negedge clk);

        // Zero-wait ALU stream.
        reset_dut();
        repeat (3) prog_q.push_back(mk(K_ALU, 0, 0, 0, 64'h0));
        run_prog(200);
        end_checks();
        check("alu_stream_pc", pc, 64'h10C);
        ints = '{4, 4};
        check_intervals(ints);

        // Latency mix: load with waits, branches, store.
        reset_dut();
        prog_q.push_back(mk(K_ALU, 0, 0, 0, 64'h0));
        prog_q.push_back(mk(K_LOAD, 2, 3, 0, 64'h0));
        prog_q.push_back(mk(K_BR, 0, 0, 0, 64'h400));
        prog_q.push_back(mk(K_STORE, 0, 0, 0, 64'h0));
        prog_q.push_back(mk(K_BR, 0, 0, 1, 64'h200));
        prog_q.push_back(mk(K_ALU, 0, 0, 0, 64'h0));
        run_prog(300);
        end_checks();
        check("branch_pc", pc, 64'h204);
        ints = '{10, 3, 4, 3, 4};
        check_intervals(ints);

        // Misaligned taken branch halts without retiring.
        reset_dut();
        prog_q.push_back(mk(K_ALU, 0, 0, 0, 64'h0));
        prog_q.push_back(mk(K_BR, 1, 0, 1, 64'h202));
        run_prog(200);
        repeat (20) @(negedge clk);
        end_checks();
        check("misalign_pc", pc, 64'h104);

        // EBREAK, then all-zero word.
        reset_dut();
        prog_q.push_back(mk(K_EBREAK, 1, 0, 0, 64'h0));
        run_prog(200);
        repeat (20) @(negedge clk);
        end_checks();
        reset_dut();
        prog_q.push_back(mk(K_ZERO, 0, 0, 0, 64'h0));
        run_prog(200);
        repeat (20) @(negedge clk);
        end_checks();

        // pc wrap at the top of the address space.
        reset_dut();
        prog_q.push_back(mk(K_BR, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC));
        prog_q.push_back(mk(K_ALU, 0, 0, 0, 64'h0));
        run_prog(200);
        end_checks();
        check("wrap_pc", pc, 64'h0);

        // Randomized episodes; the last one retires enough to wrap the counter.
        for (int e = 0; e < 5; e++) begin
            int n;
            reset_dut();
            n = (e == 4) ? 20 : 30;
            for (int i = 0; i < n; i++) begin
                int          r;
                kind_e       k;
                logic [63:0] t;
                r = $urandom_range(0, 9);
                k = (r < 3) ? K_ALU : (r < 5) ? K_LOAD : (r == 5) ? K_STORE :
                    (r == 6) ? K_LDST : K_BR;
                t = {$urandom(), $urandom()};
                t[1:0] = 2'b00;
                prog_q.push_back(mk(k, $urandom_range(0, 3), $urandom_range(0, 3),
                                    1'($urandom_range(0, 1)), t));
            end
            run_prog(3000);
            end_checks();
        end

        // Reset during a data-memory wait; the late response must be ignored.
        reset_dut();
        prog_q.push_back(mk(K_LOAD, 0, 12, 0, 64'h0));
        begin
            int n;
            n = 0;
            while (!dmem_req && n < 100) begin
                @(negedge clk);
                #1;
                n++;
            end
            check("reach_mem", 64'(dmem_req), 64'd1);
        end
        reset_dut();
        prog_q.push_back(mk(K_ALU, 0, 0, 0, 64'h0));
        run_prog(200);
        end_checks();
        check("after_midreset_pc", pc, 64'h104);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
